// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_logic_unit
// Purpose  : N-bit, 8-function bitwise logic unit with a single registered
//            output stage, valid/ready handshaking on both sides, an optional
//            accumulate mode (operand A taken from the previous result) and a
//            saturating count of accepted transactions.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            in_valid/in_ready - input handshake (op, acc_mode, clear,
//                                Input_1, Input_2 sampled on accept)
//            out_valid/out_ready - output handshake for Output/Zero
//            Output, Zero    - registered result and its zero flag
//            Count           - accepted transactions since reset/clear
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_logic_unit #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_WIDTH = 8,
    parameter logic [WIDTH-1:0] ACC_INIT  = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic                 acc_mode,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     Input_1,
    input  logic [WIDTH-1:0]     Input_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     Output,
    output logic                 Zero,
    output logic [CNT_WIDTH-1:0] Count
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_XOR  = 3'd2;
    localparam logic [2:0] c_OP_NAND = 3'd3;
    localparam logic [2:0] c_OP_NOR  = 3'd4;
    localparam logic [2:0] c_OP_XNOR = 3'd5;
    localparam logic [2:0] c_OP_ANDN = 3'd6;

    // State
    logic [WIDTH-1:0]     result_q,    result_d;
    logic                 zero_q,      zero_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     acc_q,       acc_d;
    logic [CNT_WIDTH-1:0] count_q,     count_d;

    // Combinational
    logic                 w_accept;
    logic [WIDTH-1:0]     w_op_a;
    logic [WIDTH-1:0]     w_result;

    // The single output register frees up in the same cycle it is consumed.
    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;

    // A clear arriving with an accumulate transaction must behave as if the
    // accumulator had already been re-initialised.
    always_comb begin
        w_op_a = Input_1;
        if (acc_mode) begin
            w_op_a = clear ? ACC_INIT : acc_q;
        end
    end

    always_comb begin
        w_result = w_op_a;
        case (op)
            c_OP_AND:  w_result = w_op_a & Input_2;
            c_OP_OR:   w_result = w_op_a | Input_2;
            c_OP_XOR:  w_result = w_op_a ^ Input_2;
            c_OP_NAND: w_result = ~(w_op_a & Input_2);
            c_OP_NOR:  w_result = ~(w_op_a | Input_2);
            c_OP_XNOR: w_result = ~(w_op_a ^ Input_2);
            c_OP_ANDN: w_result = w_op_a & ~Input_2;
            default:   w_result = w_op_a;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        count_d     = count_q;

        if (w_accept) begin
            result_d    = w_result;
            zero_d      = (w_result == '0);
            out_valid_d = 1'b1;
            acc_d       = w_result;
            if (clear) begin
                count_d = CNT_WIDTH'(1);
            end else if (!(&count_q)) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (clear) begin
                acc_d   = ACC_INIT;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= ACC_INIT;
            count_q     <= '0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Output    = result_q;
    assign Zero      = zero_q;
    assign Count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_logic_unit
// Purpose  : Scoreboard bench for bitwise_logic_unit. Two instances share all
//            inputs: u_dut (CNT_WIDTH=8) and u_dut2 (CNT_WIDTH=2) so that the
//            counter saturation can be observed alongside the normal flow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] op;
    logic       acc_mode;
    logic       clear;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [7:0] dout,      dout2;
    logic       zero,      zero2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] m_c8;
    logic [1:0] m_c2;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(8), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_mode(acc_mode), .clear(clear),
        .Input_1(in1), .Input_2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .Output(dout), .Zero(zero), .Count(cnt)
    );

    bitwise_logic_unit #(.WIDTH(8), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .acc_mode(acc_mode), .clear(clear),
        .Input_1(in1), .Input_2(in2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .Output(dout2), .Zero(zero2), .Count(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge where
    // out_valid && out_ready; compare it against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(dout), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("Output", 32'(dout), 32'(e.res));
                check("Zero",   32'(zero), 32'(e.z));
                check("Count",  32'(cnt),  32'(e.c8));
                check("Count_w2", 32'(cnt2), 32'(e.c2));
            end
        end
    end

    // Issue one transaction; expected result is hand-computed by the caller.
    task automatic send(input logic [2:0] o, input logic am, input logic clr,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res);
        bit done = 0;
        in_valid = 1'b1; op = o; acc_mode = am; clear = clr; in1 = a; in2 = b;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                m_c8 = clr ? 8'd1 : ((m_c8 == 8'hFF) ? m_c8 : m_c8 + 8'd1);
                m_c2 = clr ? 2'd1 : ((m_c2 == 2'd3)  ? m_c2 : m_c2 + 2'd1);
                e.res = exp_res; e.z = (exp_res == 8'h00); e.c8 = m_c8; e.c2 = m_c2;
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; clear = 1'b0; acc_mode = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        m_c8 = 8'd0; m_c2 = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; acc_mode = 1'b0; clear = 1'b0;
        in1 = 8'h00; in2 = 8'h00; out_ready = 1'b1;
        m_c8 = 8'd0; m_c2 = 2'd0;
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // ---- Reset pulsed asynchronously between edges
        #2 rst = 1'b1;
        #1;
        check("rst_Output",    32'(dout),      32'h00);
        check("rst_Zero",      32'(zero),      32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Count",     32'(cnt),       32'd0);
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        send(3'd7, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF);

        // ---- Basic ops, back-to-back
        do_clear();
        send(3'd0, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h30);
        send(3'd1, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hFC);
        send(3'd2, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hCC);
        send(3'd3, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hCF);
        send(3'd4, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h03);
        send(3'd5, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h33);
        send(3'd6, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hC0);
        send(3'd7, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hF0);
        #3 check("count_after_8", 32'(cnt), 32'd8);
        idle(1);

        // ---- Backpressure
        send(3'd0, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h30);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; in1 = 8'h01; in2 = 8'h02;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_Output",   32'(dout),     32'h30);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(3'd1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03);
        idle(1);

        // ---- Accumulate
        do_clear();
        send(3'd0, 1'b1, 1'b0, 8'h00, 8'hF7, 8'hF7);
        send(3'd0, 1'b1, 1'b0, 8'h00, 8'h7F, 8'h77);
        send(3'd0, 1'b1, 1'b0, 8'h00, 8'hFE, 8'h76);
        send(3'd2, 1'b1, 1'b0, 8'h00, 8'h76, 8'h00);

        // ---- clear together with an accept
        send(3'd7, 1'b0, 1'b0, 8'h55, 8'h00, 8'h55);
        send(3'd2, 1'b1, 1'b1, 8'h00, 8'h0F, 8'hF0);
        send(3'd7, 1'b1, 1'b0, 8'h00, 8'h00, 8'hF0);

        // ---- Counter saturation on the 2-bit instance
        do_clear();
        for (int i = 1; i <= 5; i++) begin
            send(3'd1, 1'b0, 1'b0, 8'(i), 8'h00, 8'(i));
        end
        idle(1);

        // ---- Reset asserted while a result is stalled
        out_ready = 1'b0;
        send(3'd0, 1'b0, 1'b0, 8'hAA, 8'hFF, 8'hAA);
        #2;
        check("stall_valid_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_Count",     32'(cnt),       32'd0);
        check("midrst_Count_w2",  32'(cnt2),      32'd0);
        #1 rst = 1'b0;
        m_c8 = 8'd0; m_c2 = 2'd0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(3'd7, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF);
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Parametrised successor to the 1-bit single-function AND gate component: N-bit, 8-function bitwise logic unit with a registered output and a valid/ready handshake.
- Optional accumulate mode folds each new operand into an internal accumulator, so ALU-style datapaths can build multi-word masks and reductions.
- Also keeps a saturating transaction counter.
- Sits between register-file reads and the result bus, as a custom component.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_WIDTH, 8, width of the transaction counter (>=1).
- ACC_INIT, all-ones (WIDTH bits), accumulator value after reset or clear (AND identity).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op presented this cycle.
- in_ready  output  1  block can accept this cycle.
- op  input  3  function select, sampled on accept.
- acc_mode  input  1  1 = operand A taken from accumulator instead of Input_1.
- clear  input  1  reset accumulator to ACC_INIT and Count to 0.
- Input_1  input  WIDTH  operand A.
- Input_2  input  WIDTH  operand B.
- out_valid  output  1  Output holds an unconsumed result.
- out_ready  input  1  downstream consumes the result.
- Output  output  WIDTH  registered result.
- Zero  output  1  Output == 0, registered alongside Output.
- Count  output  CNT_WIDTH  accepted transactions since reset/clear, saturating.

Behaviour:
- Reset (async, immediate on rst rising, held while high):
  - Output = 0, Zero = 1, out_valid = 0, Count = 0, accumulator = ACC_INIT.
  - in_ready = 1 once rst is low.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
  - Single output register, no internal FIFO; latency exactly 1 cycle from accept to out_valid.
  - Output and Zero hold stable while out_valid && !out_ready.
  - Back-to-back accepts at one per cycle when out_ready is held high.
- Operand A = acc_mode ? accumulator : Input_1. Operand B = Input_2.
- op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 ANDN (A & ~B), 7 PASS_A.
- On accept:
  - Output <= f(A,B); Zero <= (f(A,B)==0); out_valid <= 1.
  - accumulator <= f(A,B), regardless of acc_mode.
- On a cycle with out_valid && out_ready && !accept: out_valid <= 0; Output and Zero keep their last value.
- Count:
  - Increments by 1 on each accept.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
- clear:
  - Without accept: accumulator <= ACC_INIT, Count <= 0. Output and out_valid are untouched.
  - With accept in the same cycle: an acc_mode transaction uses ACC_INIT as operand A. accumulator <= result; Count <= 1.
  - clear never blocks in_ready.
- Inputs are ignored when not accepted, including op, acc_mode and operands while stalled.
- Reset asserted mid-stall: the pending result is discarded (out_valid 0) and the accumulator returns to ACC_INIT.

Test Plan:
- Reset: rst pulsed asynchronously between edges -> Output=0x00, Zero=1, out_valid=0, Count=0, in_ready=1; first accept with acc_mode=1, op=7 returns 0xFF.
- Basic ops, WIDTH=8, out_ready=1, A=0xF0, B=0x3C:
  - op 0..7 on consecutive cycles -> 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0xC0, 0xF0.
  - One result per cycle; Count=8.
- Backpressure: accept AND 0xF0/0x3C, then hold out_ready=0 and offer OR 0x01/0x02 for 3 cycles:
  - in_ready=0 and Output stays 0x30.
  - Raise out_ready -> the OR is accepted that cycle; the next cycle Output=0x03.
- Accumulate: clear, then acc_mode=1, op=AND, B=0xF7, 0x7F, 0xFE -> Outputs 0xF7, 0x77, 0x76; Count=3. Then op=XOR, B=0x76 -> Output 0x00, Zero=1.
- clear+accept: accumulator=0x55; same cycle clear=1, acc_mode=1, op=XOR, B=0x0F -> Output=0xF0, Count=1, next acc-mode PASS_A returns 0xF0.
- Saturation with CNT_WIDTH=2: 5 accepts -> Count sequence 1, 2, 3, 3, 3. rst mid-stall (out_valid=1, out_ready=0) -> out_valid=0, Count=0.
